// File: rtl/dmem_mmio_responder.sv
// Responder for the processor data-memory port: decodes each access into the
// data RAM, a small MMIO block (cycle counter, LEDs, TX byte FIFO) or nothing.
//
// Ports:
//   clock, reset      rising-edge clock, synchronous active-high reset
//   address_dmem      word address from the processor M stage
//   data, wren        store data and store enable
//   q_dmem            load data, combinational in the access cycle
//   ram_addr/ram_wdata/ram_wren/ram_q   single-port data RAM (same-cycle read)
//   leds              LED register contents
//   tx_data/tx_valid/tx_ready           TX FIFO drain handshake

module dmem_mmio_responder #(
    parameter int          RAM_ADDR_BITS = 12,
    parameter logic [31:0] MMIO_BASE     = 32'h0000F000,
    parameter int          FIFO_DEPTH    = 8,
    parameter int          LED_WIDTH     = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [31:0]              address_dmem,
    input  logic [31:0]              data,
    input  logic                     wren,
    output logic [31:0]              q_dmem,
    output logic [RAM_ADDR_BITS-1:0] ram_addr,
    output logic [31:0]              ram_wdata,
    output logic                     ram_wren,
    input  logic [31:0]              ram_q,
    output logic [LED_WIDTH-1:0]     leds,
    output logic [7:0]               tx_data,
    output logic                     tx_valid,
    input  logic                     tx_ready
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [1:0] OFF_CYCLE  = 2'd0;
    localparam logic [1:0] OFF_LED    = 2'd1;
    localparam logic [1:0] OFF_TXDATA = 2'd2;
    localparam logic [1:0] OFF_TXSTAT = 2'd3;

    // registered state
    logic [31:0]          cycle_q, cycle_d;
    logic [LED_WIDTH-1:0] led_q, led_d;
    logic [PW-1:0]        head_q, head_d;
    logic [PW-1:0]        tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;
    logic [7:0]           mem_q [FIFO_DEPTH];

    // decode
    logic        ram_hit;
    logic        mmio_hit;
    logic [31:0] mmio_off;
    logic        wr_ok;
    logic        wr_led;
    logic        wr_txd;
    logic        wr_stat;

    // fifo control
    logic        full;
    logic        empty;
    logic        pop;
    logic        push_ok;
    logic [31:0] stat;
    logic [31:0] rdata;

    // Offset by subtraction keeps the decode correct for any MMIO_BASE.
    assign mmio_off = address_dmem - MMIO_BASE;
    assign ram_hit  = (address_dmem[31:RAM_ADDR_BITS] == '0);
    assign mmio_hit = !ram_hit && (mmio_off < 32'd4);

    assign wr_ok   = wren && !reset;
    assign wr_led  = wr_ok && mmio_hit && (mmio_off[1:0] == OFF_LED);
    assign wr_txd  = wr_ok && mmio_hit && (mmio_off[1:0] == OFF_TXDATA);
    assign wr_stat = wr_ok && mmio_hit && (mmio_off[1:0] == OFF_TXSTAT);

    // RAM pass-through
    assign ram_addr  = address_dmem[RAM_ADDR_BITS-1:0];
    assign ram_wdata = data;
    assign ram_wren  = wr_ok && ram_hit;

    // FIFO status and handshake
    assign full     = (count_q == CW'(FIFO_DEPTH));
    assign empty    = (count_q == '0);
    assign tx_valid = !empty;
    assign tx_data  = mem_q[head_q];
    assign pop      = tx_valid && tx_ready;
    // A full FIFO still takes the byte when the head leaves this cycle.
    assign push_ok  = wr_txd && (!full || pop);

    assign leds = led_q;

    always_comb begin
        stat          = '0;
        stat[0]       = full;
        stat[1]       = empty;
        stat[2]       = ovf_q;
        stat[8 +: CW] = count_q;
    end

    always_comb begin
        rdata = '0;
        if (ram_hit) begin
            rdata = ram_q;
        end else if (mmio_hit) begin
            unique case (mmio_off[1:0])
                OFF_CYCLE:  rdata = cycle_q;
                OFF_LED:    rdata = 32'(led_q);
                OFF_TXDATA: rdata = '0;
                OFF_TXSTAT: rdata = stat;
                default:    rdata = '0;
            endcase
        end
    end

    assign q_dmem = rdata;

    always_comb begin
        cycle_d = cycle_q + 32'd1;
        led_d   = wr_led ? data[LED_WIDTH-1:0] : led_q;
        head_d  = pop ? head_q + PW'(1) : head_q;
        tail_d  = push_ok ? tail_q + PW'(1) : tail_q;
        count_d = count_q;
        unique case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // a dropped byte wins over a same-cycle clear
        ovf_d = ovf_q;
        if (wr_txd && !push_ok) begin
            ovf_d = 1'b1;
        end else if (wr_stat) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cycle_q <= '0;
            led_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            // cleared so tx_data reads 0 out of reset
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            cycle_q <= cycle_d;
            led_q   <= led_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            if (push_ok) begin
                mem_q[tail_q] <= data[7:0];
            end
        end
    end

endmodule
